// File: rtl/popcount_pkg.sv
// Shared types and helpers for the nibble-serial population counter.
package popcount_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot ones count {4,3,2,1,0} to binary; anything not one-hot maps to 0.
  function automatic logic [2:0] onehot5_to_bin(input logic [4:0] oh);
    logic [2:0] bin;
    case (oh)
      5'b00001: bin = 3'd0;
      5'b00010: bin = 3'd1;
      5'b00100: bin = 3'd2;
      5'b01000: bin = 3'd3;
      5'b10000: bin = 3'd4;
      default:  bin = 3'd0;
    endcase
    return bin;
  endfunction

endpackage

// File: rtl/nibble_ones_onehot.sv
// Four-input ones counter with a one-hot result: bit k set means k ones.
module nibble_ones_onehot
  import popcount_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [4:0]       onehot_c
);

  logic [2:0] cnt;

  // Sum the four bits, then decode the sum to a one-hot position.
  always_comb begin
    cnt      = 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
    onehot_c = 5'b00001 << cnt;
  end

endmodule

// File: rtl/popcount_seq.sv
// Population count of a DATA_W-bit word, one nibble per cycle through a
// single shared one-hot ones counter. Optional threshold compare is built
// when POPSEQ_THRESH_EN is defined (adds thr input and out_ge output).
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
`ifdef POPSEQ_THRESH_EN
  ,
  input  logic [CNT_W-1:0]  thr,
  output logic              out_ge
`endif
);

  localparam int unsigned NIB   = DATA_W / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Reject widths that do not split into whole nibbles.
  generate
    if ((DATA_W % NIB_W) != 0 || DATA_W < NIB_W) begin : g_bad_width
      $error("popcount_seq: DATA_W must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   out_count_d;
  logic [4:0]         cnt_oh;
  logic [2:0]         nib_bin;
`ifdef POPSEQ_THRESH_EN
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic               out_ge_d;
`endif

  nibble_ones_onehot u_cnt (
    .nib      (shreg_q[NIB_W-1:0]),
    .onehot_c (cnt_oh)
  );

  assign nib_bin = onehot5_to_bin(cnt_oh);

  // Next-state and datapath updates; hold everything unless the state acts.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_count_d = out_count;
`ifdef POPSEQ_THRESH_EN
    thr_d       = thr_q;
    out_ge_d    = out_ge;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
`ifdef POPSEQ_THRESH_EN
          thr_d   = thr;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q + CNT_W'(nib_bin);
        shreg_d = shreg_q >> NIB_W;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          out_count_d = acc_d;
`ifdef POPSEQ_THRESH_EN
          out_ge_d    = (acc_d >= thr_q);
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef POPSEQ_THRESH_EN
      thr_q     <= '0;
      out_ge    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_count <= out_count_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
`ifdef POPSEQ_THRESH_EN
      thr_q     <= thr_d;
      out_ge    <= out_ge_d;
`endif
    end
  end

  // Counter output must always be one-hot while it is being consumed.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == RUN) begin
      assert ($onehot(cnt_oh))
        else $error("popcount_seq: nibble counter output not one-hot");
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Directed and random checks of popcount_seq against a bit-counting model.
module tb_popcount_seq;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned NIB    = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              busy;
`ifdef POPSEQ_THRESH_EN
  logic [CNT_W-1:0]  thr;
  logic              out_ge;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_log[$];
  int res_log[$];

  popcount_seq #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
`ifdef POPSEQ_THRESH_EN
    ,
    .thr       (thr),
    .out_ge    (out_ge)
`endif
  );

  always #5 clk = ~clk;

  // Log accept cycles and delivered results at each rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_log.push_back(cyc);
    if (rst_n && out_valid && out_ready) res_log.push_back(int'(out_count));
  end

  function automatic int model_pop(input logic [DATA_W-1:0] d);
    int n = 0;
    for (int i = 0; i < int'(DATA_W); i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Send one word, hold out_ready low for 'hold' DONE cycles, check all of it.
  task automatic do_word(input logic [DATA_W-1:0] d, input int hold);
    int k;
    int busy_n;
    int exp_cnt;
    exp_cnt = model_pop(d);
    wait_ready();
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = DATA_W'($urandom);
    k = 0;
    busy_n = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    if (busy === 1'b1) busy_n++;
    check("latency", 32'(k), 32'(NIB));
    check("count", 32'(out_count), 32'(exp_cnt));
    check("busy_cycles", 32'(busy_n), 32'(NIB + 1));
`ifdef POPSEQ_THRESH_EN
    check("out_ge", 32'(out_ge), 32'(exp_cnt >= int'(thr)));
`endif
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_count", 32'(out_count), 32'(exp_cnt));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drop_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_count_kept", 32'(out_count), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    int a0;
    int d0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef POPSEQ_THRESH_EN
    thr       = CNT_W'(8);
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words.
    do_word(16'h0000, 0);
    do_word(16'hFFFF, 0);
    do_word(16'hA5C3, 0);
    do_word(16'h0001, 0);

    // Backpressure with an ignored in_valid during DONE.
    do_word(16'h00F0, 3);

    // Reset while RUN is at nibble index 2.
    wait_ready();
    res_log.delete();
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_result", 32'(res_log.size()), 32'd0);
    check("midrst_idle_valid", 32'(out_valid), 32'd0);
    do_word(16'h0F0F, 0);

    // Back-to-back with in_valid held high.
    wait_ready();
    res_log.delete();
    a0 = acc_log.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    n = 0;
    while (acc_log.size() == a0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_data = 16'h7777;
    n = 0;
    while (acc_log.size() < a0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(acc_log.size() - a0), 32'd2);
    d0 = (acc_log.size() >= a0 + 2) ? acc_log[a0 + 1] - acc_log[a0] : -1;
    check("b2b_interval", 32'(d0), 32'(NIB + 2));
    n = 0;
    while (res_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_results", 32'(res_log.size()), 32'd2);
    if (res_log.size() >= 2) begin
      check("b2b_first", 32'(res_log[0]), 32'd4);
      check("b2b_second", 32'(res_log[1]), 32'd12);
    end
    @(negedge clk);

`ifdef POPSEQ_THRESH_EN
    thr = CNT_W'(8);
    do_word(16'hA5C3, 0);
    do_word(16'h0F00, 0);
    thr = CNT_W'(0);
    do_word(16'h0000, 0);
    do_word(16'h8421, 1);
    thr = CNT_W'(8);
`endif

    // Random words with random backpressure.
    for (int i = 0; i < 24; i++) begin
`ifdef POPSEQ_THRESH_EN
      thr = CNT_W'($urandom_range(0, DATA_W));
`endif
      do_word(DATA_W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
